cache_nway: RTL and testbench

Parametrised N-way set-associative, write-through data cache between the core's load/store port and the word-addressed `ram` model. It generalises the fixed 2-way cache to configurable ways, sets and widths. It adds a valid/ready request handshake, a req/ack memory handshake, round-robin victim selection per set, and optional hit/miss statistics. One word per line; no bursts.

---
 rtl/cache_nway.sv | 234 +++++++++++++++++++++++
 tb/tb_cache_nway.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway.sv
// N-way set-associative write-through cache with round-robin replacement.
// Define CACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module cache_nway #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_hit_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StMemRd, StMemWr} state_e;

    state_e state_q, state_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic [WAY_W-1:0]  hit_way_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_hit_q;
    logic              mem_req_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way;
    logic              vic_free;
    logic [WAY_W-1:0]  vic_way;
    logic [WAY_W-1:0]  ptr_next;
    logic              mem_done;
    logic              fill;
    logic              wr_update;

    assign idx      = addr_q[IDX_W-1:0];
    assign tag      = addr_q[ADDR_W-1:IDX_W];
    assign mem_done = mem_req_q && mem_ack_i;
    assign fill     = (state_q == StMemRd) && mem_done;
    assign wr_update = (state_q == StMemWr) && mem_done && hit_q;

    // Parallel tag compare; at most one valid way can match.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way first; otherwise the set's round-robin pointer.
    always_comb begin
        vic_free = 1'b0;
        vic_way  = ptr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_free && !valid_q[idx][w]) begin
                vic_free = 1'b1;
                vic_way  = WAY_W'(w);
            end
        end
        ptr_next = (ptr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) state_d = StLookup;
            end
            StLookup: begin
                if (wr_q)        state_d = StMemWr;
                else if (lk_hit) state_d = StIdle;
                else             state_d = StMemRd;
            end
            StMemRd, StMemWr: begin
                if (mem_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_hit_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= (state_d == StIdle);
            mem_req_q    <= (state_d == StMemRd) || (state_d == StMemWr);
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        wr_q    <= req_wr_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                StLookup: begin
                    hit_q     <= lk_hit;
                    hit_way_q <= lk_way;
                    if (!wr_q && lk_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= data_q[idx][lk_way];
                        resp_hit_q   <= 1'b1;
                    end else begin
                        mem_wr_q    <= wr_q;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= wdata_q;
                    end
                end
                StMemRd: begin
                    if (mem_done) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= mem_rdata_i;
                        resp_hit_q   <= 1'b0;
                    end
                end
                StMemWr: begin
                    if (mem_done) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= hit_q;
                        mem_wr_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only valid bits and pointers need reset; tags and data are qualified by valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (fill) begin
            valid_q[idx][vic_way] <= 1'b1;
            if (!vic_free) ptr_q[idx] <= ptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (fill) begin
                tag_q[idx][vic_way]  <= tag;
                data_q[idx][vic_way] <= mem_rdata_i;
            end else if (wr_update) begin
                data_q[idx][hit_way_q] <= wdata_q;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (resp_valid_q) begin
            if (resp_hit_q) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_hit_o   = resp_hit_q;
    assign mem_req_o    = mem_req_q;
    assign mem_wr_o     = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_cache_nway.sv
// Directed self-checking bench for cache_nway (WAYS=2, SETS=32).
// Counter checks are compiled in only when CACHE_STATS_EN is defined.
module tb_cache_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_nway #(
        .WAYS  (2),
        .SETS  (32),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wr_i    (req_wr),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_data_o (resp_data),
        .resp_hit_o  (resp_hit),
        .mem_req_o   (mem_req),
        .mem_wr_o    (mem_wr),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; memory acks after d waiting cycles of mem_req.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int d, input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic exp_hit, input string tag);
        int   mem_cyc;
        int   lat;
        logic got;
        logic exp_mem;
        exp_mem = wr || !exp_hit;
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_cyc = 0;
        lat     = 0;
        got     = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
            end else begin
                if (mem_req) begin
                    chk({tag, " mem_addr"}, 64'(mem_addr), 64'(addr));
                    chk({tag, " mem_wr"}, 64'(mem_wr), 64'(wr));
                    if (wr) chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(wdata));
                    chk({tag, " busy"}, 64'(req_ready), 64'd0);
                    mem_ack   = (mem_cyc == d);
                    mem_rdata = rdata;
                    mem_cyc++;
                end
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        chk({tag, " resp_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, " latency"}, 64'(lat), exp_mem ? 64'(d + 1) : 64'd0);
            chk({tag, " mem_cycles"}, 64'(mem_cyc), exp_mem ? 64'(d + 1) : 64'd0);
            chk({tag, " mem_req_low"}, 64'(mem_req), 64'd0);
            chk({tag, " ready_at_resp"}, 64'(req_ready), 64'd1);
            chk({tag, " hit"}, 64'(resp_hit), 64'(exp_hit));
            if (!wr) chk({tag, " data"}, 64'(resp_data), 64'(exp_data));
        end
        @(negedge clk);
        chk({tag, " pulse"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_hit", 64'(resp_hit), 64'd0);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_wr", 64'(mem_wr), 64'd0);
        chk("rst resp_data", 64'(resp_data), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release ready", 64'(req_ready), 64'd1);

        // Cold miss then hit.
        access(1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "rd40 miss");
        access(1'b0, 32'h40, 32'h0, 0, 32'h0, 32'hDEADBEEF, 1'b1, "rd40 hit");

        // Set 5: third fill evicts way 0, pointer moves to 1.
        access(1'b0, 32'h005, 32'h0, 0, 32'hA5, 32'hA5, 1'b0, "fill005");
        access(1'b0, 32'h025, 32'h0, 1, 32'hB5, 32'hB5, 1'b0, "fill025");
        access(1'b0, 32'h045, 32'h0, 0, 32'hC5, 32'hC5, 1'b0, "fill045");
        access(1'b0, 32'h025, 32'h0, 0, 32'h0, 32'hB5, 1'b1, "rd025 hit");
        access(1'b0, 32'h005, 32'h0, 0, 32'hA5, 32'hA5, 1'b0, "rd005 miss");
        access(1'b0, 32'h045, 32'h0, 0, 32'h0, 32'hC5, 1'b1, "rd045 hit");

        // Write-through hit updates the line.
        access(1'b1, 32'h40, 32'h12345678, 0, 32'h0, 32'h0, 1'b1, "wr40 hit");
        access(1'b0, 32'h40, 32'h0, 0, 32'h0, 32'h12345678, 1'b1, "rd40 new");

        // Write miss does not allocate.
        access(1'b1, 32'h80, 32'h55, 1, 32'h0, 32'h0, 1'b0, "wr80 miss");
        access(1'b0, 32'h80, 32'h0, 0, 32'h55, 32'h55, 1'b0, "rd80 miss");

        // Long ack wait, then reset mid-transaction with ack asserted.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("wait mem_req", 64'(mem_req), 64'd1);
            chk("wait mem_addr", 64'(mem_addr), 64'h100);
            chk("wait ready", 64'(req_ready), 64'd0);
            chk("wait resp", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        rst_n     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("abort mem_req", 64'(mem_req), 64'd0);
        chk("abort resp", 64'(resp_valid), 64'd0);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("abort ready", 64'(req_ready), 64'd1);
        chk("abort no resp", 64'(resp_valid), 64'd0);

        // Ack with no request outstanding.
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray ack mem_req", 64'(mem_req), 64'd0);
            chk("stray ack resp", 64'(resp_valid), 64'd0);
        end
        mem_ack = 1'b0;

        access(1'b0, 32'h100, 32'h0, 1, 32'h0100AAAA, 32'h0100AAAA, 1'b0, "rd100 after rst");
        access(1'b0, 32'h40, 32'h0, 0, 32'h12345678, 32'h12345678, 1'b0, "rd40 after rst");
        access(1'b0, 32'h100, 32'h0, 0, 32'h0, 32'h0100AAAA, 1'b1, "rd100 hit a");
        access(1'b0, 32'h40, 32'h0, 0, 32'h0, 32'h12345678, 1'b1, "rd40 hit b");
        access(1'b0, 32'h100, 32'h0, 0, 32'h0, 32'h0100AAAA, 1'b1, "rd100 hit c");
        repeat (2) @(negedge clk);
`ifdef CACHE_STATS_EN
        chk("hit_cnt", 64'(hit_cnt), 64'd3);
        chk("miss_cnt", 64'(miss_cnt), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
